// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO write- and read-side controllers.
// Pointer vectors are carried at the widest supported width; callers
// zero-extend into ptr_vec_t and truncate the result back to their own width.
package async_fifo_pkg;

   localparam int unsigned MaxPtrWidth = 16;

   typedef logic [MaxPtrWidth:0] ptr_vec_t;

   function automatic ptr_vec_t bin2gray(input ptr_vec_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits contribute nothing.
   function automatic ptr_vec_t gray2bin(input ptr_vec_t gray);
      ptr_vec_t bin;
      bin = gray;
      for (int unsigned i = 1; i <= MaxPtrWidth; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: write request, synchronised-from pointer
// input and the controller's address/flag outputs.
// Optional feature macro: FIFO_WR_ALMOST_FULL_EN adds o_wr_almost_full and
// o_wr_level.
interface fifo_wr_ctrl_if #(
   parameter int unsigned PtrWidth = 3
) ();

   logic                i_wr_en;
   logic [PtrWidth:0]   i_rd_gptr;
   logic [PtrWidth-1:0] o_wr_ptr;
   logic [PtrWidth:0]   o_wr_gptr;
   logic                o_wr_full;
   logic                o_wr_overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
   logic                o_wr_almost_full;
   logic [PtrWidth:0]   o_wr_level;

   modport master (
      output i_wr_en, i_rd_gptr,
      input  o_wr_ptr, o_wr_gptr, o_wr_full, o_wr_overflow,
      input  o_wr_almost_full, o_wr_level
   );

   modport slave (
      input  i_wr_en, i_rd_gptr,
      output o_wr_ptr, o_wr_gptr, o_wr_full, o_wr_overflow,
      output o_wr_almost_full, o_wr_level
   );
`else
   modport master (
      output i_wr_en, i_rd_gptr,
      input  o_wr_ptr, o_wr_gptr, o_wr_full, o_wr_overflow
   );

   modport slave (
      input  i_wr_en, i_rd_gptr,
      output o_wr_ptr, o_wr_gptr, o_wr_full, o_wr_overflow
   );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchroniser with asynchronous active-low reset. Shared by the
// write- and read-side FIFO controllers for crossing Gray pointers.
module sync_2ff #(
   parameter int unsigned Width = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] i_d,
   output logic [Width-1:0] o_q
);

   logic [Width-1:0] q1;

   // First stage may go metastable; second stage gives it a cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1  <= '0;
         o_q <= '0;
      end else begin
         q1  <= i_d;
         o_q <= q1;
      end
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO (clk_wr domain): binary/Gray write
// pointers, read-pointer synchroniser, registered full flag and sticky
// overflow flag.
// Optional feature macro: FIFO_WR_ALMOST_FULL_EN adds a registered occupancy
// (o_wr_level) and almost-full flag computed against the synchronised read
// pointer.
module fifo_wr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int unsigned Depth            = 8,
   parameter int unsigned PtrWidth         = $clog2(Depth),
   parameter int unsigned AlmostFullThresh = Depth - 2
) (
   input logic           clk_wr,
   input logic           rst_n,
   fifo_wr_ctrl_if.slave bus
);

   localparam int unsigned PW1 = PtrWidth + 1;

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("fifo_wr_ctrl: Depth must be a power of 2 and >= 2");
   end
   if (PtrWidth != $clog2(Depth) || PtrWidth > MaxPtrWidth) begin : g_bad_ptr
      $error("fifo_wr_ctrl: PtrWidth must equal clog2(Depth) and fit MaxPtrWidth");
   end
   if (AlmostFullThresh > Depth) begin : g_bad_thresh
      $error("fifo_wr_ctrl: AlmostFullThresh must not exceed Depth");
   end

   logic [PtrWidth:0] wbin;
   logic [PtrWidth:0] wbin_next;
   logic [PtrWidth:0] wgray_q;
   logic [PtrWidth:0] wgray_next;
   logic [PtrWidth:0] rq2;
   logic [PtrWidth:0] full_cmp;
   logic              wr_accept;
   logic              full_q;
   logic              full_next;
   logic              overflow_q;
   logic              overflow_next;

   sync_2ff #(
      .Width (PW1)
   ) u_rd_sync (
      .clk   (clk_wr),
      .rst_n (rst_n),
      .i_d   (bus.i_rd_gptr),
      .o_q   (rq2)
   );

   // Next pointer, full and overflow state from the current request and rq2.
   // Full compares against the read pointer with its top two Gray bits
   // inverted, written as an XOR mask so Depth=2 needs no special case.
   always_comb begin
      wr_accept     = bus.i_wr_en & ~full_q;
      wbin_next     = wbin + PW1'(wr_accept);
      wgray_next    = PW1'(bin2gray(ptr_vec_t'(wbin_next)));
      full_cmp      = rq2 ^ (PW1'(3) << (PtrWidth - 1));
      full_next     = (wgray_next == full_cmp);
      overflow_next = overflow_q | (bus.i_wr_en & full_q);
   end

   // Pointer and flag registers.
   always_ff @(posedge clk_wr or negedge rst_n) begin
      if (!rst_n) begin
         wbin       <= '0;
         wgray_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wbin       <= wbin_next;
         wgray_q    <= wgray_next;
         full_q     <= full_next;
         overflow_q <= overflow_next;
      end
   end

   assign bus.o_wr_ptr      = wbin[PtrWidth-1:0];
   assign bus.o_wr_gptr     = wgray_q;
   assign bus.o_wr_full     = full_q;
   assign bus.o_wr_overflow = overflow_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
   logic [PtrWidth:0] rbin_sync;
   logic [PtrWidth:0] level_next;
   logic [PtrWidth:0] level_q;
   logic              almost_full_next;
   logic              almost_full_q;

   // Occupancy against the lagging read pointer; reads pessimistically high.
   always_comb begin
      rbin_sync        = PW1'(gray2bin(ptr_vec_t'(rq2)));
      level_next       = wbin_next - rbin_sync;
      almost_full_next = (level_next >= PW1'(AlmostFullThresh));
   end

   // Level and almost-full registers.
   always_ff @(posedge clk_wr or negedge rst_n) begin
      if (!rst_n) begin
         level_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         level_q       <= level_next;
         almost_full_q <= almost_full_next;
      end
   end

   assign bus.o_wr_level       = level_q;
   assign bus.o_wr_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at Depth=8: a per-cycle vector table for
// fill / overflow / drain-release / refill, then hand-written sequences for
// mid-cycle asynchronous reset and pointer wrap-around.
// With FIFO_WR_ALMOST_FULL_EN defined, o_wr_level and o_wr_almost_full are
// also compared.
module tb_fifo_wr_ctrl;

   typedef struct {
      logic       wr;
      logic [3:0] rd;
      logic [2:0] ptr;
      logic [3:0] gptr;
      logic       full;
      logic       ovf;
      logic [3:0] lvl;
      logic       af;
   } vec_t;

   logic clk_wr = 1'b0;
   logic rst_n  = 1'b0;

   always #5 clk_wr = ~clk_wr;

   fifo_wr_ctrl_if #(.PtrWidth(3)) bus ();

   fifo_wr_ctrl #(
      .Depth (8)
   ) dut (
      .clk_wr (clk_wr),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   vec_t tbl[$];

   function automatic vec_t mk(input logic wr, input logic [3:0] rd,
                               input logic [2:0] ptr, input logic [3:0] gptr,
                               input logic full, input logic ovf,
                               input logic [3:0] lvl, input logic af);
      vec_t v;
      v.wr = wr; v.rd = rd; v.ptr = ptr; v.gptr = gptr;
      v.full = full; v.ovf = ovf; v.lvl = lvl; v.af = af;
      return v;
   endfunction

   function automatic logic [3:0] g4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [2:0] eptr,
                        input logic [3:0] egptr, input logic efull,
                        input logic eovf);
      n_vec++;
      if (bus.o_wr_ptr !== eptr || bus.o_wr_gptr !== egptr ||
          bus.o_wr_full !== efull || bus.o_wr_overflow !== eovf) begin
         n_err++;
         $display("FAIL %s: got ptr=%0h gptr=%0h full=%b ovf=%b, want ptr=%0h gptr=%0h full=%b ovf=%b",
                  name, bus.o_wr_ptr, bus.o_wr_gptr, bus.o_wr_full, bus.o_wr_overflow,
                  eptr, egptr, efull, eovf);
      end
   endtask

`ifdef FIFO_WR_ALMOST_FULL_EN
   task automatic check_af(input string name, input logic [3:0] elvl, input logic eaf);
      n_vec++;
      if (bus.o_wr_level !== elvl || bus.o_wr_almost_full !== eaf) begin
         n_err++;
         $display("FAIL %s: got level=%0d af=%b, want level=%0d af=%b",
                  name, bus.o_wr_level, bus.o_wr_almost_full, elvl, eaf);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] prev_g;
      logic [3:0] wb;

      // wr, rd_gptr, ptr, gptr, full, ovf, level, almost_full
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h0, 1, 4'h1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 4'h0, 2, 4'h3, 0, 0, 2, 0));
      tbl.push_back(mk(1, 4'h0, 3, 4'h2, 0, 0, 3, 0));
      tbl.push_back(mk(1, 4'h0, 4, 4'h6, 0, 0, 4, 0));
      tbl.push_back(mk(1, 4'h0, 5, 4'h7, 0, 0, 5, 0));
      tbl.push_back(mk(1, 4'h0, 6, 4'h5, 0, 0, 6, 1));
      tbl.push_back(mk(1, 4'h0, 7, 4'h4, 0, 0, 7, 1));
      tbl.push_back(mk(1, 4'h0, 0, 4'hC, 1, 0, 8, 1));
      tbl.push_back(mk(1, 4'h0, 0, 4'hC, 1, 1, 8, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'hC, 1, 1, 8, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'hC, 1, 1, 8, 1));
      tbl.push_back(mk(0, 4'h2, 0, 4'hC, 1, 1, 8, 1));
      tbl.push_back(mk(0, 4'h2, 0, 4'hC, 1, 1, 8, 1));
      tbl.push_back(mk(0, 4'h2, 0, 4'hC, 0, 1, 5, 0));
      tbl.push_back(mk(1, 4'h2, 1, 4'hD, 0, 1, 6, 1));
      tbl.push_back(mk(1, 4'h2, 2, 4'hF, 0, 1, 7, 1));
      tbl.push_back(mk(1, 4'h2, 3, 4'hE, 1, 1, 8, 1));
      tbl.push_back(mk(1, 4'h2, 3, 4'hE, 1, 1, 8, 1));

      bus.i_wr_en   = 1'b0;
      bus.i_rd_gptr = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk_wr);
      #1;
      check("reset_held", 3'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk_wr);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk_wr);
         bus.i_wr_en   = tbl[i].wr;
         bus.i_rd_gptr = tbl[i].rd;
         @(posedge clk_wr);
         #1;
         check($sformatf("vec%0d", i), tbl[i].ptr, tbl[i].gptr, tbl[i].full, tbl[i].ovf);
`ifdef FIFO_WR_ALMOST_FULL_EN
         check_af($sformatf("vec%0d_af", i), tbl[i].lvl, tbl[i].af);
`endif
      end

      // Asynchronous reset landing mid-cycle while full and overflowed.
      @(negedge clk_wr);
      bus.i_wr_en = 1'b0;
      @(posedge clk_wr);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", 3'h0, 4'h0, 1'b0, 1'b0);
`ifdef FIFO_WR_ALMOST_FULL_EN
      check_af("async_reset_af", 4'h0, 1'b0);
`endif
      bus.i_rd_gptr = '0;
      @(negedge clk_wr);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_wr);
         #1;
         check($sformatf("post_reset_idle%0d", i), 3'h0, 4'h0, 1'b0, 1'b0);
      end

      // Wrap-around: 20 writes with the read pointer trailing by two.
      wb     = 4'h0;
      prev_g = 4'h0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_wr);
         bus.i_wr_en   = 1'b1;
         bus.i_rd_gptr = (n >= 2) ? g4(4'(n - 2)) : 4'h0;
         @(posedge clk_wr);
         #1;
         wb = wb + 4'h1;
         check($sformatf("wrap%0d", n), wb[2:0], g4(wb), 1'b0, 1'b0);
         n_vec++;
         if ($countones(prev_g ^ bus.o_wr_gptr) != 1) begin
            n_err++;
            $display("FAIL wrap%0d_onebit: got gptr %0h -> %0h, want exactly one bit changed",
                     n, prev_g, bus.o_wr_gptr);
         end
         prev_g = bus.o_wr_gptr;
      end
      @(negedge clk_wr);
      bus.i_wr_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
